// File: rtl/phy_tx_pkg.sv
// Shared constants and types for the PHY transmit scheduler.
package phy_tx_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned LANES  = 4;
   localparam int unsigned LANE_W = 2;
   localparam int unsigned BIT_W  = 3;

   localparam logic [BYTE_W-1:0] COMMA_BC = 8'hBC;
   localparam logic [BYTE_W-1:0] IDLE_7C  = 8'h7C;
   localparam logic [BYTE_W-1:0] OFF_WORD = 8'h00;

   // Link state; the encoding is visible on the state output.
   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_SYNC   = 2'd1,
      ST_ACTIVE = 2'd2
   } tx_state_e;

   // One word as it is placed on the line.
   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              k;
      logic [LANE_W-1:0] lane;
   } tx_word_t;

endpackage

// File: rtl/phy_tx_scheduler_rr_arbiter4.sv
// Four-way round-robin grant: search starts one past the previous winner.
module rr_arbiter4
   import phy_tx_pkg::*;
(
   input  logic [LANES-1:0]  req_i,
   input  logic [LANE_W-1:0] last_grant_i,
   output logic [LANE_W-1:0] gnt_idx_c_o,
   output logic              gnt_any_c_o
);

   logic [LANE_W-1:0] cand;

   // First requesting lane in rotating priority order; previous winner checked last.
   always_comb begin
      gnt_idx_c_o = '0;
      gnt_any_c_o = 1'b0;
      cand        = '0;
      for (int unsigned off = 1; off <= LANES; off++) begin
         cand = last_grant_i + LANE_W'(off);
         if (!gnt_any_c_o && req_i[cand]) begin
            gnt_any_c_o = 1'b1;
            gnt_idx_c_o = cand;
         end
      end
   end

endmodule

// File: rtl/phy_tx_scheduler.sv
// Word scheduler for the PHY transmit path: link bring-up commas, round-robin
// lane arbitration, idle fill and MSB-first serialization on the bit clock.
module phy_tx_scheduler
   import phy_tx_pkg::*;
#(
   parameter int unsigned SYNC_WORDS = 4   // comma words after enable, >= 1
)
(
   input  logic              clk_32f,
   input  logic              default_values,
   input  logic              enable,
   input  logic              valid0,
   input  logic              valid1,
   input  logic              valid2,
   input  logic              valid3,
   input  logic [BYTE_W-1:0] data_in0,
   input  logic [BYTE_W-1:0] data_in1,
   input  logic [BYTE_W-1:0] data_in2,
   input  logic [BYTE_W-1:0] data_in3,
   output logic              pop0,
   output logic              pop1,
   output logic              pop2,
   output logic              pop3,
   output logic              data_out,
   output logic              byte_strobe,
   output logic              k_flag,
   output logic [LANE_W-1:0] lane_id,
   output logic [1:0]        state
);

   localparam int unsigned SYNC_W = $clog2(SYNC_WORDS + 1);

   localparam tx_word_t COMMA_WORD = '{data: COMMA_BC, k: 1'b1, lane: '0};
   localparam tx_word_t IDLE_WORD  = '{data: IDLE_7C,  k: 1'b1, lane: '0};
   localparam tx_word_t OFF_TXWORD = '{data: OFF_WORD, k: 1'b0, lane: '0};

   logic [BIT_W-1:0]  bit_cnt_q,     bit_cnt_d;
   logic [BYTE_W-1:0] shreg_q,       shreg_d;
   tx_state_e         state_q,       state_d;
   logic [SYNC_W-1:0] sync_cnt_q,    sync_cnt_d;
   logic [LANE_W-1:0] last_grant_q,  last_grant_d;
   logic [LANES-1:0]  pop_q,         pop_d;
   logic              byte_strobe_q, byte_strobe_d;
   logic              k_flag_q,      k_flag_d;
   logic [LANE_W-1:0] lane_id_q,     lane_id_d;

   logic [LANES-1:0]  req;
   logic [LANE_W-1:0] gnt_idx;
   logic              gnt_any;
   logic [BYTE_W-1:0] lane_byte;
   logic              arb_take;
   tx_word_t          word;

   assign req = {valid3, valid2, valid1, valid0};

   rr_arbiter4 u_arb (
      .req_i        (req),
      .last_grant_i (last_grant_q),
      .gnt_idx_c_o  (gnt_idx),
      .gnt_any_c_o  (gnt_any)
   );

   // Byte of the lane the arbiter currently favours.
   always_comb begin
      lane_byte = data_in0;
      unique case (gnt_idx)
         2'd0:    lane_byte = data_in0;
         2'd1:    lane_byte = data_in1;
         2'd2:    lane_byte = data_in2;
         default: lane_byte = data_in3;
      endcase
   end

   // State/word decision at the boundary; shift otherwise.
   always_comb begin
      bit_cnt_d     = bit_cnt_q + 3'd1;
      shreg_d       = {shreg_q[BYTE_W-2:0], 1'b0};
      state_d       = state_q;
      sync_cnt_d    = sync_cnt_q;
      last_grant_d  = last_grant_q;
      pop_d         = '0;
      byte_strobe_d = 1'b0;
      k_flag_d      = k_flag_q;
      lane_id_d     = lane_id_q;
      word          = OFF_TXWORD;
      arb_take      = 1'b0;

      if (bit_cnt_q == 3'd7) begin
         bit_cnt_d     = 3'd0;
         byte_strobe_d = 1'b1;

         unique case (state_q)
            ST_OFF: begin
               if (enable) begin
                  word       = COMMA_WORD;
                  sync_cnt_d = SYNC_W'(1);
                  state_d    = ST_SYNC;
               end
            end
            ST_SYNC: begin
               if (!enable) begin
                  state_d    = ST_OFF;
                  sync_cnt_d = '0;
               end else if (sync_cnt_q < SYNC_W'(SYNC_WORDS)) begin
                  word       = COMMA_WORD;
                  sync_cnt_d = sync_cnt_q + SYNC_W'(1);
               end else begin
                  // Final comma already sent: arbitrate in this same boundary.
                  state_d  = ST_ACTIVE;
                  arb_take = 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (!enable) begin
                  state_d    = ST_OFF;
                  sync_cnt_d = '0;
               end else begin
                  arb_take = 1'b1;
               end
            end
            default: begin
               state_d    = ST_OFF;
               sync_cnt_d = '0;
            end
         endcase

         if (arb_take) begin
            if (gnt_any) begin
               word           = '{data: lane_byte, k: 1'b0, lane: gnt_idx};
               last_grant_d   = gnt_idx;
               pop_d[gnt_idx] = 1'b1;
            end else begin
               word = IDLE_WORD;
            end
         end

         shreg_d   = word.data;
         k_flag_d  = word.k;
         lane_id_d = word.lane;
      end
   end

   // State and output registers; reset leaves bit_cnt at 7 so the next edge loads a word.
   always_ff @(posedge clk_32f) begin
      if (default_values) begin
         bit_cnt_q     <= 3'd7;
         shreg_q       <= OFF_WORD;
         state_q       <= ST_OFF;
         sync_cnt_q    <= '0;
         last_grant_q  <= 2'd3;
         pop_q         <= '0;
         byte_strobe_q <= 1'b0;
         k_flag_q      <= 1'b0;
         lane_id_q     <= '0;
      end else begin
         bit_cnt_q     <= bit_cnt_d;
         shreg_q       <= shreg_d;
         state_q       <= state_d;
         sync_cnt_q    <= sync_cnt_d;
         last_grant_q  <= last_grant_d;
         pop_q         <= pop_d;
         byte_strobe_q <= byte_strobe_d;
         k_flag_q      <= k_flag_d;
         lane_id_q     <= lane_id_d;
      end
   end

   assign data_out    = shreg_q[BYTE_W-1];
   assign byte_strobe = byte_strobe_q;
   assign k_flag      = k_flag_q;
   assign lane_id     = lane_id_q;
   assign state       = state_q;
   assign pop0        = pop_q[0];
   assign pop1        = pop_q[1];
   assign pop2        = pop_q[2];
   assign pop3        = pop_q[3];

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Bench for phy_tx_scheduler: word-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_phy_tx_scheduler;

   localparam int SW = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en;
   logic [3:0] vld;
   logic [7:0] din [4];
   logic [3:0] pop;
   logic       dout, strobe, kf;
   logic [1:0] lid, st;

   phy_tx_scheduler #(.SYNC_WORDS(SW)) u_dut (
      .clk_32f(clk), .default_values(rst), .enable(en),
      .valid0(vld[0]), .valid1(vld[1]), .valid2(vld[2]), .valid3(vld[3]),
      .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
      .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
      .data_out(dout), .byte_strobe(strobe), .k_flag(kf), .lane_id(lid), .state(st)
   );

   // Second instance with a single comma word.
   logic       rst1;
   logic [3:0] pop1;
   logic       dout1, strobe1, kf1;
   logic [1:0] lid1, st1;

   phy_tx_scheduler #(.SYNC_WORDS(1)) u_dut1 (
      .clk_32f(clk), .default_values(rst1), .enable(1'b1),
      .valid0(1'b1), .valid1(1'b1), .valid2(1'b1), .valid3(1'b1),
      .data_in0(8'h11), .data_in1(8'h22), .data_in2(8'h33), .data_in3(8'h44),
      .pop0(pop1[0]), .pop1(pop1[1]), .pop2(pop1[2]), .pop3(pop1[3]),
      .data_out(dout1), .byte_strobe(strobe1), .k_flag(kf1), .lane_id(lid1), .state(st1)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int pop_cnt = 0;
   bit chk_on = 1'b0;
   bit done1 = 1'b0;

   // Reference model: current word, bit position within it, and link bookkeeping.
   int         m_pos = 7;
   logic [7:0] m_word = 8'h00;
   logic       m_k = 1'b0;
   logic [1:0] m_lane = 2'd0;
   int         m_mode = 0;      // 0 off, 1 sync, 2 active
   int         m_commas = 0;
   int         m_last = 3;
   int         m_pop = -1;

   int         t_mode, t_commas, t_last, t_pop, t_l;
   logic [7:0] t_word;
   logic       t_k;

   always @(posedge clk) begin
      if (rst) begin
         m_pos <= 7; m_word <= 8'h00; m_k <= 1'b0; m_lane <= 2'd0;
         m_mode <= 0; m_commas <= 0; m_last <= 3; m_pop <= -1;
      end else if (m_pos != 7) begin
         m_pos <= m_pos + 1;
      end else begin
         t_mode = m_mode; t_commas = m_commas; t_last = m_last; t_pop = -1;
         t_word = 8'h00; t_k = 1'b0;
         if (!en) begin
            t_mode = 0; t_commas = 0;
         end else if (m_mode == 0 || (m_mode == 1 && m_commas < SW)) begin
            t_mode = 1; t_commas = m_commas + 1; t_word = 8'hBC; t_k = 1'b1;
         end else begin
            t_mode = 2; t_word = 8'h7C; t_k = 1'b1;
            for (int o = 1; o <= 4; o++) begin
               t_l = (m_last + o) % 4;
               if (t_pop < 0 && vld[t_l]) t_pop = t_l;
            end
            if (t_pop >= 0) begin
               t_word = din[t_pop]; t_k = 1'b0; t_last = t_pop;
            end
         end
         m_pos <= 0; m_word <= t_word; m_k <= t_k;
         m_lane <= (t_pop >= 0) ? 2'(t_pop) : 2'd0;
         m_mode <= t_mode; m_commas <= t_commas; m_last <= t_last; m_pop <= t_pop;
      end
   end

   // Per-cycle compare plus word capture framed by the model.
   logic [7:0] sh = 8'h00;
   logic [7:0] got_w [$];
   logic       got_k [$];
   logic [1:0] got_l [$];
   logic [1:0] got_s [$];
   logic [3:0] e_pop;
   logic [10:0] e_vec, a_vec;

   always @(negedge clk) begin
      if (chk_on) begin
         e_pop = (m_pos == 0 && m_pop >= 0) ? 4'(1 << m_pop) : 4'd0;
         e_vec = {m_word[7-m_pos], (m_pos == 0), m_k, m_lane, 2'(m_mode), e_pop};
         a_vec = {dout, strobe, kf, lid, st, pop};
         n_cmp++;
         if (a_vec !== e_vec) begin
            n_bad++;
            $display("FAIL cycle_check t=%0t got{dout,strb,k,lane,state,pop}=%b required=%b",
                     $time, a_vec, e_vec);
         end
         pop_cnt += $countones(pop);
         sh = {sh[6:0], dout};
         if (m_pos == 7) begin
            got_w.push_back(sh); got_k.push_back(kf);
            got_l.push_back(lid); got_s.push_back(st);
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic to_pos(input int p);
      if (m_pos == p) return;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (m_pos == p) return;
      end
      chk("to_pos_timeout", m_pos, p);
   endtask

   task automatic clr();
      got_w.delete(); got_k.delete(); got_l.delete(); got_s.delete();
   endtask

   task automatic chk_word(input string name, input int idx, input int w, input int k, input int l);
      if (idx >= got_w.size()) begin
         chk({name, "_missing"}, got_w.size(), idx + 1);
      end else begin
         chk({name, "_data"}, int'(got_w[idx]), w);
         chk({name, "_k"}, int'(got_k[idx]), k);
         chk({name, "_lane"}, int'(got_l[idx]), l);
      end
   endtask

   // SYNC_WORDS=1 instance: one comma, then lane 0 onward.
   initial begin
      logic [7:0] s1;
      logic       k_at [4];
      logic [1:0] l_at [4];
      logic       sb_at [4];
      logic [7:0] w_at [4];
      rst1 = 1'b1;
      s1 = 8'h00;
      repeat (3) @(negedge clk);
      #1 rst1 = 1'b0;
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            s1 = {s1[6:0], dout1};
            if (b == 0) begin
               k_at[w] = kf1; l_at[w] = lid1; sb_at[w] = strobe1;
            end
         end
         w_at[w] = s1;
      end
      chk("sw1_w0_data", int'(w_at[0]), 8'hBC);
      chk("sw1_w0_k", int'(k_at[0]), 1);
      chk("sw1_w1_data", int'(w_at[1]), 8'h11);
      chk("sw1_w1_k", int'(k_at[1]), 0);
      chk("sw1_w1_lane", int'(l_at[1]), 0);
      chk("sw1_w2_data", int'(w_at[2]), 8'h22);
      chk("sw1_w2_lane", int'(l_at[2]), 1);
      chk("sw1_w3_data", int'(w_at[3]), 8'h33);
      chk("sw1_w3_lane", int'(l_at[3]), 2);
      chk("sw1_strobe", int'({sb_at[0], sb_at[1], sb_at[2], sb_at[3]}), 4'hF);
      done1 = 1'b1;
   end

   initial begin
      int p0;
      rst = 1'b1; en = 1'b0; vld = 4'h0;
      for (int l = 0; l < 4; l++) din[l] = 8'h00;
      cyc(1);
      chk_on = 1'b1;
      cyc(2);
      chk("reset_state", int'({dout, strobe, kf, lid, st, pop}), 0);

      // Bring-up with no data: four commas then idles.
      rst = 1'b0; en = 1'b1;
      clr(); p0 = pop_cnt;
      cyc(48);
      for (int i = 0; i < 4; i++) chk_word($sformatf("t1_comma%0d", i), i, 8'hBC, 1, 0);
      chk_word("t1_idle4", 4, 8'h7C, 1, 0);
      chk_word("t1_idle5", 5, 8'h7C, 1, 0);
      chk("t1_state_active", int'(got_s[4]), 2);
      chk("t1_no_pops", pop_cnt - p0, 0);

      // All lanes valid: strict rotation from lane 0.
      to_pos(7); clr();
      vld = 4'hF; din[0] = 8'hFF; din[1] = 8'hEE; din[2] = 8'hDD; din[3] = 8'hCC;
      p0 = pop_cnt;
      cyc(40);
      chk_word("t2_w0", 0, 8'hFF, 0, 0);
      chk_word("t2_w1", 1, 8'hEE, 0, 1);
      chk_word("t2_w2", 2, 8'hDD, 0, 2);
      chk_word("t2_w3", 3, 8'hCC, 0, 3);
      chk_word("t2_w4", 4, 8'hFF, 0, 0);
      chk("t2_pops", pop_cnt - p0, 5);

      // Lane 2 alone, then lanes 0 and 2 alternate.
      to_pos(7); clr();
      vld = 4'b0100; din[2] = 8'h99;
      cyc(24);
      chk_word("t3_solo0", 0, 8'h99, 0, 2);
      chk_word("t3_solo2", 2, 8'h99, 0, 2);
      clr();
      vld = 4'b0101; din[0] = 8'hBB;
      cyc(32);
      chk_word("t3_alt0", 0, 8'hBB, 0, 0);
      chk_word("t3_alt1", 1, 8'h99, 0, 2);
      chk_word("t3_alt2", 2, 8'hBB, 0, 0);
      chk_word("t3_alt3", 3, 8'h99, 0, 2);

      // Drop enable mid-word, then re-enable.
      to_pos(3);
      en = 1'b0;
      to_pos(7); clr();
      cyc(24);
      chk_word("t4_off0", 0, 8'h00, 0, 0);
      chk_word("t4_off2", 2, 8'h00, 0, 0);
      chk("t4_state_off", int'(got_s[1]), 0);
      clr();
      en = 1'b1; vld = 4'hF;
      din[0] = 8'hFF; din[1] = 8'hEE; din[2] = 8'hDD; din[3] = 8'hCC;
      cyc(48);
      for (int i = 0; i < 4; i++) chk_word($sformatf("t4_comma%0d", i), i, 8'hBC, 1, 0);
      chk("t4_data_after_commas_k", int'(got_k[4]), 0);

      // Reset in the middle of a word.
      to_pos(4);
      rst = 1'b1;
      cyc(1);
      chk("t5_abort", int'({dout, st, pop}), 0);
      rst = 1'b0; clr();
      cyc(8);
      chk_word("t5_first", 0, 8'hBC, 1, 0);

      // Random traffic respecting the hold-until-pop rule.
      for (int c = 0; c < 4000; c++) begin
         for (int l = 0; l < 4; l++) begin
            if (vld[l]) begin
               if (m_pos == 0 && m_pop == l) begin
                  if ($urandom_range(1, 0) == 1) din[l] = 8'($urandom);
                  else vld[l] = 1'b0;
               end
            end else if ($urandom_range(7, 0) == 0) begin
               vld[l] = 1'b1; din[l] = 8'($urandom);
            end else begin
               din[l] = 8'($urandom);
            end
         end
         if ($urandom_range(63, 0) == 0) en = ~en;
         rst = ($urandom_range(1499, 0) == 0);
         cyc(1);
      end
      rst = 1'b0;
      cyc(2);

      for (int i = 0; i < 1000 && !done1; i++) @(negedge clk);
      if (!done1) chk("sw1_timeout", 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/phy_tx_scheduler.md
# phy_tx_scheduler

Word-level controller for the PHY transmit path, running on the serial bit clock.
- Brings the link up with a fixed run of `0xBC` comma words, then round-robin arbitrates the four 8-bit input lanes onto one MSB-first serial stream.
- Fills unused word slots with `0x7C` idle words.
- Sits between the per-lane byte sources and the line, replacing separate mux and serializer sequencing with one scheduler.

## Interface
- `SYNC_WORDS`, default 4: number of `0xBC` comma words sent after link enable; must be ≥1.
- `clk_32f` input, 1 bit: bit clock, the only clock in the block.
- `default_values` input, 1 bit: synchronous, active-high reset.
- `enable` input, 1 bit: link enable; sampled only at word boundaries.
- `valid0..valid3` inputs, 1 bit each: lane has a byte ready; must stay stable until that lane's pop.
- `data_in0..data_in3` inputs, 8 bits each: lane byte.
- `pop0..pop3` outputs, 1 bit each: one-cycle pulse, byte of that lane accepted.
- `data_out` output, 1 bit: serial line, MSB first.
- `byte_strobe` output, 1 bit: high on the first bit of every word.
- `k_flag` output, 1 bit: current word is a control word (`0xBC`/`0x7C`).
- `lane_id` output, 2 bits: source lane of the current data word; 0 for control words.
- `state` output, 2 bits: OFF=0, SYNC=1, ACTIVE=2.

## Operation
- 3-bit `bit_cnt` counts 0..7; `data_out` = `shreg[7]`, with `shreg` shifted left each cycle.
- Word boundary is the edge where `bit_cnt`==7; the next word loads on that edge and `bit_cnt` wraps to 0.
- The load decision uses `enable`/`valid*` sampled at that edge:
  - OFF: if `enable`, load `0xBC`, `sync_cnt`=1, go to SYNC. Otherwise load `0x00` with `k_flag`=0.
  - SYNC: if not `enable`, load `0x00` and go to OFF. Otherwise, if `sync_cnt` < `SYNC_WORDS`, load `0xBC` and increment `sync_cnt`. Otherwise go to ACTIVE and apply the ACTIVE rule in the same boundary. Result: exactly `SYNC_WORDS` commas.
  - ACTIVE: if not `enable`, load `0x00` and go to OFF. Otherwise search lanes from (`last_grant`+1) mod 4 upward and grant the first lane with valid=1:
    - load its byte, `k_flag`=0, `lane_id`=lane, `last_grant`=lane, pulse its pop;
    - if no lane is valid, load `0x7C`, `k_flag`=1, and leave `last_grant` unchanged.
- `sync_cnt` width is clog2(`SYNC_WORDS`+1); it saturates and is cleared on entry to OFF.
- Deasserting `enable` never truncates a word; the word in flight completes.

## Timing
- Reset (`default_values`=1 at an edge) sets:
  - `bit_cnt`=7, `shreg`=`0x00`, `data_out`=0;
  - state=OFF, `sync_cnt`=0, `last_grant`=3 (lane 0 has first priority);
  - `pop*`=0, `byte_strobe`=0, `k_flag`=0, `lane_id`=0.
- The first edge after reset release is a word boundary. Reset mid-word aborts that word immediately.
- Outputs are registered:
  - `byte_strobe`, `k_flag`, `lane_id`, `state` and `pop*` update on the load edge.
  - `byte_strobe` and `pop*` are high for exactly the cycle in which `bit_cnt`==0.
- Latency from a lane's valid being sampled at a boundary to its MSB on `data_out` is 1 cycle. The full byte is on the line by 8 cycles.
- Upstream has 8 cycles after a pop to present its next byte.
- Maximum throughput is one byte every 8 `clk_32f` cycles, shared across all lanes.
- Mid-word changes on `valid*`/`enable` are ignored.

## Structure
- Shared package `phy_tx_pkg` holds:
  - `COMMA_BC`=8'hBC, `IDLE_7C`=8'h7C, `OFF_WORD`=8'h00;
  - the 2-bit state encoding constants.
- One sub-module, `rr_arbiter4`: combinational round-robin grant from 4 requests plus `last_grant`, with outputs grant index and `any`. All other logic (FSM, counters, shift register) stays in `phy_tx_scheduler`.

## Test plan
1. Reset, then `enable`=1 with no valids:
   - `data_out` shows 10111100 four times, then 01111100 repeating;
   - `k_flag`=1 throughout, `byte_strobe` every 8 cycles, no pops.
2. All lanes valid with `FF`/`EE`/`DD`/`CC` held:
   - after 4 commas, words are `FF`,`EE`,`DD`,`CC`,`FF`…;
   - `lane_id` 0,1,2,3,0; each pop fires once per 32 cycles, coincident with `byte_strobe`.
3. Only lane 2 valid (`0x99`): every word is `0x99`, `lane_id`=2. Then lane 0 also becomes valid (`0xBB`): words alternate `BB`,`99`.
4. Drop `enable` at `bit_cnt`=3 in ACTIVE:
   - the current word finishes, the next words are `0x00` with state=OFF;
   - re-enable produces exactly 4 `0xBC` before data resumes.
5. Assert `default_values` mid-word:
   - the next cycle shows `data_out`=0, state=OFF, no pops;
   - after release with `enable`=1, the first word is `0xBC`.
6. `SYNC_WORDS`=1, all lanes valid: exactly one `0xBC`, then lane 0 data.
